// File: rtl/bcd_7seg_scanner_if.sv
// Bus between the BCD source / display pins and the 3-digit 7-segment scanner.
// The master drives the capture strobe, the digits and blank.
// The slave (the scanner) drives the anode, segment and slot-tick outputs.
interface bcd_7seg_scanner_if;
  logic       load;
  logic [3:0] bcd_h;
  logic [3:0] bcd_t;
  logic [3:0] bcd_o;
  logic       blank;
  logic [2:0] an;
  logic [6:0] seg;
  logic       busy_slot;

  modport master (
    output load, bcd_h, bcd_t, bcd_o, blank,
    input  an, seg, busy_slot
  );

  modport slave (
    input  load, bcd_h, bcd_t, bcd_o, blank,
    output an, seg, busy_slot
  );
endinterface

// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed 3-digit 7-segment driver.
// - Captures hundreds/tens/ones into shadow registers on load.
// - Scans ones -> tens -> hundreds, with REFRESH_DIV cycles per slot.
// - At the start of each slot, DEAD_CYCLES cycles keep all anodes off.
// - an, seg and busy_slot are registered. They lag the scan counter by one
//   cycle. Both anodes and segments are active-low.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// in the hundreds and tens positions.
module bcd_7seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_7seg_scanner_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    S_ONES  = 2'd0,
    S_TENS  = 2'd1,
    S_HUNDS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sh_h_q, sh_h_d;
  logic [3:0]       sh_t_q, sh_t_d;
  logic [3:0]       sh_o_q, sh_o_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             busy_q, busy_d;

  logic [3:0]       digit_s;
  logic [2:0]       sel_s;
  logic             lit_s;
  logic             dead_s;

  // Active-low {g,f,e,d,c,b,a} decode. Non-BCD codes show a lone dash.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h3F;
    endcase
    return r;
  endfunction

  // Shadow next value. The freshly captured digit feeds the output decode on
  // the same edge, so a load shows on the pins in the very next cycle.
  always_comb begin
    if (bus.load) begin
      sh_h_d = bus.bcd_h;
      sh_t_d = bus.bcd_t;
      sh_o_d = bus.bcd_o;
    end else begin
      sh_h_d = sh_h_q;
      sh_t_d = sh_t_q;
      sh_o_d = sh_o_q;
    end
  end

  // Slot counter and digit sequencing: ones -> tens -> hundreds -> ones.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      case (state_q)
        S_ONES:  state_d = S_TENS;
        S_TENS:  state_d = S_HUNDS;
        S_HUNDS: state_d = S_ONES;
        default: state_d = S_ONES;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pick the digit for the current slot, and decide whether it may light.
  always_comb begin
    digit_s = 4'd0;
    sel_s   = 3'b111;
    lit_s   = 1'b0;
    case (state_q)
      S_ONES: begin
        digit_s = sh_o_d;
        sel_s   = 3'b110;
        lit_s   = 1'b1;
      end
      S_TENS: begin
        digit_s = sh_t_d;
        sel_s   = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
        lit_s   = !((sh_h_d == 4'd0) && (sh_t_d == 4'd0));
`else
        lit_s   = 1'b1;
`endif
      end
      S_HUNDS: begin
        digit_s = sh_h_d;
        sel_s   = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
        lit_s   = (sh_h_d != 4'd0);
`else
        lit_s   = 1'b1;
`endif
      end
      default: begin
        digit_s = 4'd0;
        sel_s   = 3'b111;
        lit_s   = 1'b0;
      end
    endcase
  end

  // Next pin values. Dead time, blank or a suppressed digit all force dark.
  always_comb begin
    dead_s = (cnt_q < CNT_DEAD);
    busy_d = (cnt_q == {CNT_W{1'b0}});
    an_d   = 3'b111;
    seg_d  = 7'h7F;
    if (!bus.blank && !dead_s && lit_s) begin
      an_d  = sel_s;
      seg_d = dec7(digit_s);
    end else begin
      an_d  = 3'b111;
      seg_d = 7'h7F;
    end
  end

  // All state and output registers. rst wins over load and restarts the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ONES;
      cnt_q   <= {CNT_W{1'b0}};
      sh_h_q  <= 4'd0;
      sh_t_q  <= 4'd0;
      sh_o_q  <= 4'd0;
      an_q    <= 3'b111;
      seg_q   <= 7'h7F;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_h_q  <= sh_h_d;
      sh_t_q  <= sh_t_d;
      sh_o_q  <= sh_o_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.busy_slot = busy_q;

endmodule
